// File: rtl/ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer:
// FSM states, bus-driver select indices and IR field positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam int IR_W      = 32;
  localparam int IR_OP_HI  = 31;
  localparam int IR_RA_HI  = 26;
  localparam int IR_RB_HI  = 22;
  localparam int IR_RC_HI  = 18;

  // Bus_Encoder_signals bit positions; R0..R15 occupy bits 0..15
  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHI    = 18;
  localparam int SEL_ZLO    = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int SEL_C      = 23;

  localparam logic [4:0] MUL_OP_DEF  = 5'd14;
  localparam logic [4:0] DIV_OP_DEF  = 5'd15;
  localparam logic [4:0] HALT_OP_DEF = 5'd27;

endpackage

// File: rtl/control_sequencer_if.sv
// Connection bundle between the control sequencer and the DataPath:
// IR/handshake inputs, control enables and status.
interface control_sequencer_if #(
  parameter int NUM_REGS  = 16,
  parameter int OP_W      = 5,
  parameter int BUS_SEL_W = 24,
  parameter int CNT_W     = 16
);
  logic                 run;
  logic [31:0]          ir;
  logic                 mem_ready;
  logic [BUS_SEL_W-1:0] bus_sel;
  logic [NUM_REGS-1:0]  reg_in;
  logic                 PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC, Read;
  logic [OP_W-1:0]      alu_op;
  logic                 busy;
  logic                 halted;
  logic                 illegal;
  logic                 mem_fault;
  logic [CNT_W-1:0]     instr_count;

  modport master (
    input  run, ir, mem_ready,
    output bus_sel, reg_in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
           IncPC, Read, alu_op, busy, halted, illegal, mem_fault, instr_count
  );

  modport slave (
    output run, ir, mem_ready,
    input  bus_sel, reg_in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
           IncPC, Read, alu_op, busy, halted, illegal, mem_fault, instr_count
  );
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decoder: maps the registered FSM state plus the IR fields
// onto DataPath enables, the one-hot bus select and the ALU opcode.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int              NUM_REGS    = 16,
  parameter int              OP_W        = 5,
  parameter int              BUS_SEL_W   = 24,
  parameter int              NUM_ALU_OPS = 16,
  parameter logic [OP_W-1:0] MUL_OP      = MUL_OP_DEF,
  parameter logic [OP_W-1:0] DIV_OP      = DIV_OP_DEF,
  parameter logic [OP_W-1:0] HALT_OP     = HALT_OP_DEF
) (
  input  state_t               state,
  input  logic [31:0]          ir,
  output logic [BUS_SEL_W-1:0] bus_sel,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic                 PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC, Read,
  output logic [OP_W-1:0]      alu_op,
  output logic                 busy,
  output logic                 halted,
  output logic                 op_halt,
  output logic                 op_illegal,
  output logic                 op_wide
);
  localparam int RI_W  = $clog2(NUM_REGS);
  localparam int SEL_W = $clog2(BUS_SEL_W);

  logic [OP_W-1:0]  op_s;
  logic [RI_W-1:0]  ra_s, rb_s, rc_s;
  logic             op_alu_s;
  logic [SEL_W-1:0] sel_idx_s;
  logic             sel_en_s;
  logic             unused_ir_s;

  assign op_s        = ir[IR_OP_HI -: OP_W];
  assign ra_s        = ir[IR_RA_HI -: RI_W];
  assign rb_s        = ir[IR_RB_HI -: RI_W];
  assign rc_s        = ir[IR_RC_HI -: RI_W];
  assign unused_ir_s = ^ir[IR_RC_HI-RI_W:0];

  assign op_alu_s   = {{(32-OP_W){1'b0}}, op_s} < NUM_ALU_OPS;
  assign op_halt    = (op_s == HALT_OP);
  assign op_illegal = !op_alu_s && !op_halt;
  assign op_wide    = (op_s == MUL_OP) || (op_s == DIV_OP);
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);

  // Per-state control decode; IDLE and HALT drive nothing
  always_comb begin
    sel_en_s  = 1'b0;
    sel_idx_s = '0;
    reg_in    = '0;
    PCin  = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin   = 1'b0;
    Zin   = 1'b0; HIin = 1'b0; LOin  = 1'b0; IncPC = 1'b0; Read  = 1'b0;
    alu_op = '0;
    case (state)
      S_T0: begin
        sel_en_s = 1'b1; sel_idx_s = SEL_W'(SEL_PC);
        MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        sel_en_s = 1'b1; sel_idx_s = SEL_W'(SEL_ZLO);
        PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        sel_en_s = 1'b1; sel_idx_s = SEL_W'(SEL_MDR);
        IRin = 1'b1;
      end
      S_T3: begin
        if (op_alu_s) begin
          sel_en_s = 1'b1; sel_idx_s = SEL_W'(rb_s);
          Yin = 1'b1;
        end else begin
          sel_en_s = 1'b0;
        end
      end
      S_T4: begin
        sel_en_s = 1'b1; sel_idx_s = SEL_W'(rc_s);
        Zin = 1'b1; alu_op = op_s;
      end
      S_T5: begin
        sel_en_s = 1'b1; sel_idx_s = SEL_W'(SEL_ZLO);
        if (op_wide) begin
          LOin = 1'b1;
        end else begin
          reg_in[ra_s] = 1'b1;
        end
      end
      S_T6: begin
        sel_en_s = 1'b1; sel_idx_s = SEL_W'(SEL_ZHI);
        HIin = 1'b1;
      end
      default: sel_en_s = 1'b0;
    endcase
    bus_sel            = '0;
    bus_sel[sel_idx_s] = sel_en_s;
  end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired instruction-fetch/execute sequencer: FSM, memory wait timer,
// sticky fault flags and retired-instruction counter.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int              NUM_REGS    = 16,
  parameter int              OP_W        = 5,
  parameter int              BUS_SEL_W   = 24,
  parameter int              NUM_ALU_OPS = 16,
  parameter logic [OP_W-1:0] MUL_OP      = MUL_OP_DEF,
  parameter logic [OP_W-1:0] DIV_OP      = DIV_OP_DEF,
  parameter logic [OP_W-1:0] HALT_OP     = HALT_OP_DEF,
  parameter int              MEM_TMO     = 15,
  parameter int              CNT_W       = 16
) (
  input logic           clock,
  input logic           clear,
  control_sequencer_if.master bus
);
  localparam int                WAIT_W   = $clog2(MEM_TMO);
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TMO - 1);

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              illegal_r;
  logic              fault_r;
  logic [CNT_W-1:0]  count_r;
  logic              op_halt_s, op_illegal_s, op_wide_s;
  state_t            end_state_s;

  assign end_state_s     = bus.run ? S_T0 : S_IDLE;
  assign bus.illegal     = illegal_r;
  assign bus.mem_fault   = fault_r;
  assign bus.instr_count = count_r;

  ctrl_decode #(
    .NUM_REGS(NUM_REGS), .OP_W(OP_W), .BUS_SEL_W(BUS_SEL_W), .NUM_ALU_OPS(NUM_ALU_OPS),
    .MUL_OP(MUL_OP), .DIV_OP(DIV_OP), .HALT_OP(HALT_OP)
  ) u_decode (
    .state(state_r), .ir(bus.ir),
    .bus_sel(bus.bus_sel), .reg_in(bus.reg_in),
    .PCin(bus.PCin), .IRin(bus.IRin), .MARin(bus.MARin), .MDRin(bus.MDRin),
    .Yin(bus.Yin), .Zin(bus.Zin), .HIin(bus.HIin), .LOin(bus.LOin),
    .IncPC(bus.IncPC), .Read(bus.Read), .alu_op(bus.alu_op),
    .busy(bus.busy), .halted(bus.halted),
    .op_halt(op_halt_s), .op_illegal(op_illegal_s), .op_wide(op_wide_s)
  );

  // Sequencer state, wait timer, sticky flags and retire counter
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
      illegal_r  <= 1'b0;
      fault_r    <= 1'b0;
      count_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: if (bus.run) state_r <= S_T0;
        S_T0: begin
          wait_cnt_r <= '0;
          state_r    <= S_T1;
        end
        S_T1: begin
          if (bus.mem_ready) begin
            state_r <= S_T2;
          end else if (wait_cnt_r == TMO_LAST) begin
            fault_r <= 1'b1;
            state_r <= S_HALT;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
          end
        end
        S_T2: state_r <= S_T3;
        S_T3: begin
          if (op_halt_s) begin
            count_r <= count_r + CNT_W'(1'b1);
            state_r <= S_HALT;
          end else if (op_illegal_s) begin
            illegal_r <= 1'b1;
            state_r   <= end_state_s;
          end else begin
            state_r <= S_T4;
          end
        end
        S_T4: state_r <= S_T5;
        S_T5: begin
          if (op_wide_s) begin
            state_r <= S_T6;
          end else begin
            count_r <= count_r + CNT_W'(1'b1);
            state_r <= end_state_s;
          end
        end
        S_T6: begin
          count_r <= count_r + CNT_W'(1'b1);
          state_r <= end_state_s;
        end
        S_HALT: state_r <= S_HALT;
        default: state_r <= S_IDLE;
      endcase
    end
  end
endmodule
